// File: rtl/fir_out_requant.sv
//==============================================================================
// Module      : fir_out_requant
// Description : Decimates the full-precision FIR output, rounds and saturates it
//               to OUT_W bits, and buffers the results in a first-word-fall-through
//               FIFO. Saturation and overflow are reported as sticky flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_out_requant #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sat_flag,
    output logic                       ovf_flag,
    input  logic                       clr_flags
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic signed [IN_W:0] c_half = (IN_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [IN_W:0] c_max  = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] c_min  = -c_max - (IN_W+1)'(1);
    localparam logic [PW-1:0]        c_last = PW'(DECIM - 1);
    localparam logic [LW-1:0]        c_full = LW'(DEPTH);

    logic [PW-1:0]          r_phase;
    logic                   r_s1_valid;
    logic signed [IN_W:0]   r_s1_data;
    logic                   r_s2_valid;
    logic                   r_s2_sat;
    logic [OUT_W-1:0]       r_s2_data;
    logic [OUT_W-1:0]       r_mem [DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [LW-1:0]          r_level;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_sat;
    logic                   r_ovf;

    logic                   w_keep;
    logic signed [IN_W:0]   w_round;
    logic                   w_hi;
    logic                   w_lo;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic                   w_head_new;

    // One extra bit keeps the rounding add from wrapping near full scale.
    assign w_keep  = in_valid && (r_phase == '0);
    assign w_round = ($signed({in_data[IN_W-1], in_data}) + c_half) >>> SHIFT;

    assign w_hi = (r_s1_data > c_max);
    assign w_lo = (r_s1_data < c_min);

    assign w_pop      = (r_level != '0) && out_ready;
    assign w_wr       = r_s2_valid && ((r_level != c_full) || w_pop);
    assign w_drop     = r_s2_valid && (r_level == c_full) && !w_pop;
    // The written word becomes head when nothing else remains in front of it.
    assign w_head_new = w_wr && ((r_level == '0) || ((r_level == LW'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (in_valid) begin
                r_phase <= (r_phase == c_last) ? '0 : r_phase + PW'(1);
            end
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_data <= w_round;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_sat   <= r_s1_valid && (w_hi || w_lo);
            if (r_s1_valid) begin
                if (w_hi) begin
                    r_s2_data <= c_max[OUT_W-1:0];
                end else if (w_lo) begin
                    r_s2_data <= c_min[OUT_W-1:0];
                end else begin
                    r_s2_data <= r_s1_data[OUT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_s2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);

            if (w_head_new) begin
                r_out_data <= r_s2_data;
            end else if (w_pop && (r_level > LW'(1))) begin
                r_out_data <= r_mem[r_rptr + AW'(1)];
            end

            if (r_s2_sat) begin
                r_sat <= 1'b1;
            end else if (clr_flags) begin
                r_sat <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = r_out_data;
    assign level     = r_level;
    assign sat_flag  = r_sat;
    assign ovf_flag  = r_ovf;

endmodule

`default_nettype wire

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of `fir_filter`. Consumes its 32-bit signed full-precision output.
- Per sample: decimates by DECIM, rounds and shifts out the Q15 coefficient gain, saturates to 16-bit signed.
- Buffers results in a small FIFO with a valid/ready output for the next consumer (DAC interface or host capture).
- Flags saturation and FIFO overflow as sticky status bits.

Parameters:
IN_W, 32, input width (matches fir_filter data_out)
OUT_W, 16, output sample width
SHIFT, 15, right-shift applied before saturation (Q15 coefficient scaling)
DECIM, 4, decimation factor (>=1; 1 = no decimation)
DEPTH, 8, FIFO depth in entries (power of two)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data valid this cycle (tie high behind fir_filter, which produces one sample per clock)
in_data  input  IN_W  signed FIR output sample
out_valid  output  1  out_data holds an unread FIFO entry
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  OUT_W  signed requantized sample
level  output  $clog2(DEPTH)+1  current FIFO occupancy
sat_flag  output  1  sticky: at least one sample saturated
ovf_flag  output  1  sticky: at least one decimated sample dropped because FIFO full
clr_flags  input  1  clears sat_flag and ovf_flag

Behaviour:
- Reset (rst high at a rising edge) forces:
  - out_valid=0, out_data=0, level=0, sat_flag=0, ovf_flag=0.
  - Decimation phase=0, pipeline valids=0, FIFO pointers=0.
  - Reset mid-operation discards all buffered and in-flight samples.
- Decimation:
  - Phase counter runs 0..DECIM-1 and advances only on in_valid, wrapping to 0.
  - A sample is kept when in_valid=1 and phase==0. All others are discarded.
  - The first valid sample after reset is kept.
- Stage 1 (registered):
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT.
  - Computed in IN_W+1 bits so the rounding add cannot wrap.
  - Arithmetic shift; ties round toward +infinity.
- Stage 2 (registered, the FIFO write):
  - s = clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1).
  - Clamp asserts sat_flag the cycle after the write attempt, whether or not the write succeeds.
- Latency:
  - Sample kept at edge k is written at edge k+2.
  - If the FIFO was empty, out_valid=1 and out_data=s are visible after edge k+2 (first-word-fall-through).
- FIFO:
  - out_data always shows the head entry while out_valid=1.
  - A pop occurs when out_valid & out_ready.
  - When empty: out_valid=0, out_data holds its last value, out_ready ignored.
  - Full with write and no pop: sample dropped, ovf_flag set, contents/level unchanged.
  - Full with simultaneous write and pop: both happen, level stays DEPTH, no overflow.
  - Empty with write: out_valid rises next cycle; a pop cannot occur in the same cycle.
  - Pointers wrap modulo DEPTH. level = writes - pops, range 0..DEPTH.
- Flags:
  - Clear on clr_flags=1.
  - If a set event coincides with clr_flags, the set wins.
- No combinational path from in_* to out_*. out_ready reaches only FIFO pop logic.

Test Plan:
1. Rounding, DECIM=1, out_ready=1:
   - in_data 16384 → 1; 16383 → 0; -16384 → 0; -16385 → -1.
   - in_data 1073676289 (32767*32767) → 32766.
   - Each output appears 2 cycles after input; sat_flag stays 0.
2. Saturation:
   - in_data 0x7FFFFFFF → 32767, sat_flag=1.
   - in_data -1073741824 → -32768 with no new saturation (check after clr_flags).
   - in_data -1073758209 → -32768, sat_flag=1.
   - clr_flags pulse → sat_flag=0.
3. Decimation, DECIM=4:
   - Ramp in_data=k*32768, k=0..15, continuous in_valid → outputs 0,4,8,12 only.
   - Drop in_valid for 3 cycles mid-ramp → phase holds, kept indices unchanged.
4. Overflow, out_ready=0, DECIM=1:
   - Feed 9 samples 1..9 (×32768) → level=8, ovf_flag=1.
   - Raise out_ready → drain yields 1..8 in order, then out_valid=0.
5. Full with concurrent push/pop:
   - Fill to 8, then hold out_ready=1 while feeding 10 → level stays 8, ovf_flag stays 0, output order preserved.
6. Reset mid-operation:
   - With level=5 and a sample in stage 1, assert rst for one cycle.
   - Next cycle: out_valid=0, level=0, flags 0.
   - First post-reset sample appears 2 cycles after being applied.
